ahb_arbiter_param: RTL and testbench
====================================

// Module: ahb_arbiter_param
// PURPOSE
//  Parametrised AHB bus arbiter: successor to the fixed 4-master arbiter. Selects one of
//  NUM_MASTERS requesters and drives HGRANT, HMASTER and HMASTLOCK to the address/data muxes.
//  Adds round-robin or fixed priority, locked transfers, fixed-burst beat tracking and an
//  INCR fairness cut-off. Sits between the master ports and the interconnect muxes.
// PARAMETERS
//  NUM_MASTERS     4   number of masters, 2..16
//  MW              $clog2(NUM_MASTERS)  HMASTER width (derived localparam)
//  PRIORITY_MODE   0   0 = round-robin, 1 = fixed (index 0 highest)
//  DEFAULT_MASTER  0   master granted when nobody requests
//  MAX_INCR_BEATS  16  accepted beats of an undefined INCR burst before forced re-arbitration
// PORTS
//  HCLK       in   1            bus clock
//  HRESETn    in   1            asynchronous active-low reset
//  HREQ       in   NUM_MASTERS  bus request, one bit per master
//  HLOCK      in   NUM_MASTERS  locked-transfer request, one bit per master
//  HREADY     in   1            transfer accepted / bus advance
//  HTRANS     in   2            current owner's transfer type (00 IDLE,01 BUSY,10 NONSEQ,11 SEQ)
//  HBURST     in   3            current owner's burst type
//  HGRANT     out  NUM_MASTERS  one-hot grant, registered
//  HMASTER    out  MW           address-phase owner index, registered
//  HMASTLOCK  out  1            owner's transfer is locked, registered
// BEHAVIOUR
//  Reset (async, HRESETn=0): HGRANT=1<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0,
//   beats_left=0, incr_cnt=0, rr_ptr=DEFAULT_MASTER. Reset mid-burst abandons the burst.
//  HGRANT is always exactly one-hot; nothing changes in any cycle where HREADY=0.
//  Beat tracking (on posedge with HREADY=1): NONSEQ loads beats_left=len-1
//   (SINGLE 0, x4 3, x8 7, x16 15; INCR 0) and incr_cnt=1; SEQ decrements beats_left
//   (saturates at 0) and increments incr_cnt (saturates at MAX_INCR_BEATS). IDLE/BUSY: no change.
//  Handover point (posedge, HREADY=1), grant may move when owner not locked and any of:
//   a) HTRANS=IDLE; b) accepted beat is final beat of a fixed burst (NONSEQ+SINGLE, or
//   SEQ with beats_left==1); c) HBURST=INCR, incr_cnt>=MAX_INCR_BEATS-1 on this accepted
//   beat, and some other master requests.
//  BUSY or a fixed burst in progress holds the grant even if the owner drops HREQ.
//  Lock: if HLOCK[owner]&HREQ[owner], grant stays with owner at every handover point.
//  Selection at handover: no HREQ -> DEFAULT_MASTER. PRIORITY_MODE=1: lowest requesting
//   index. PRIORITY_MODE=0: first requester searching rr_ptr+1, rr_ptr+2, ... wrapping
//   modulo NUM_MASTERS; owner is chosen only if it is the sole requester. rr_ptr<=winner.
//  Latency: new HGRANT appears 1 cycle after the handover edge; HMASTER and HMASTLOCK
//   (=HLOCK[winner]) follow on the next HREADY=1 edge (address phase of new owner).
//  HREQ changes alone never move the grant except via condition a).
// TESTING
//  1 Reset, HREQ=0 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 (NUM_MASTERS=4 default).
//  2 M0 INCR4 (NONSEQ+3 SEQ), HREQ=0011 throughout -> HGRANT stays 0001 for all 4 beats,
//    becomes 0010 on the cycle after the 4th accepted beat; HMASTER=1 one HREADY later.
//  3 RR, HREQ=1111 held, all IDLE -> grants rotate 0001,0010,0100,1000,0001 per handover.
//  4 PRIORITY_MODE=1, HREQ=1010 -> grant 0010; HREQ=1000 at handover -> 1000.
//  5 M2 INCR with HLOCK[2]=1, HREQ=0110, 20 SEQ beats -> grant held 0100, HMASTLOCK=1;
//    same without lock, MAX_INCR_BEATS=16 -> grant moves to 0010 after 16th accepted beat.
//  6 HREADY=0 for 5 cycles during final beat -> HGRANT frozen; HRESETn low mid-burst
//    -> HGRANT=0001 immediately (async), beats_left=0.

Source files
------------

// File: rtl/ahb_arbiter_param.sv
// ahb_arbiter_param: parametrised AHB arbiter with round-robin or fixed priority, locked transfers,
// fixed-burst beat tracking and an INCR fairness cut-off.
module ahb_arbiter_param #(
  parameter int NUM_MASTERS    = 4,
  parameter int PRIORITY_MODE  = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_INCR_BEATS = 16,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic                   HREADY,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);
  localparam int CW = $clog2(MAX_INCR_BEATS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INCR_BEATS);
  localparam logic [CW-1:0] CNT_CUT = CW'(MAX_INCR_BEATS - 1);
  localparam logic [NUM_MASTERS-1:0] GRANT_RST = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [MW-1:0] master_q, master_d, rr_q, rr_d, owner, winner;
  logic lock_q, lock_d;
  logic [3:0] bl_q, bl_d, len_m1;
  logic [CW-1:0] cnt_q, cnt_d, cnt_prev;
  logic is_ns, is_seq, locked, final_beat, cut, handover;
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++) owner = grant_q[i] ? MW'(i) : owner;
    winner = MW'(DEFAULT_MASTER);
    if (PRIORITY_MODE == 1)
      for (int i = NUM_MASTERS - 1; i >= 0; i--) winner = HREQ[i] ? MW'(i) : winner;
    else
      for (int k = NUM_MASTERS; k >= 1; k--)
        winner = HREQ[(int'(rr_q) + k) % NUM_MASTERS] ? MW'((int'(rr_q) + k) % NUM_MASTERS) : winner;
    is_ns = HTRANS == T_NONSEQ;
    is_seq = HTRANS == T_SEQ;
    len_m1 = HBURST[2:1] == 2'b00 ? 4'd0 : HBURST[2:1] == 2'b01 ? 4'd3 : HBURST[2:1] == 2'b10 ? 4'd7 : 4'd15;
    locked = HLOCK[owner] & HREQ[owner];
    final_beat = (is_ns && HBURST == 3'b000) || (is_seq && bl_q == 4'd1);
    // a NONSEQ starts a fresh INCR count, so the stale counter must not trigger the cut-off
    cnt_prev = is_ns ? '0 : cnt_q;
    cut = (is_ns || is_seq) && HBURST == 3'b001 && cnt_prev >= CNT_CUT && |(HREQ & ~grant_q);
    handover = HREADY && !locked && (HTRANS == T_IDLE || final_beat || cut);
    grant_d = handover ? NUM_MASTERS'(1) << winner : grant_q;
    rr_d = handover ? winner : rr_q;
    master_d = HREADY ? owner : master_q;
    lock_d = HREADY ? HLOCK[owner] : lock_q;
    bl_d = !HREADY ? bl_q : is_ns ? len_m1 : is_seq ? (bl_q == 4'd0 ? 4'd0 : bl_q - 4'd1) : bl_q;
    cnt_d = !HREADY ? cnt_q : is_ns ? CW'(1) : (is_seq && cnt_q < CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q <= GRANT_RST;
      master_q <= MW'(DEFAULT_MASTER);
      rr_q <= MW'(DEFAULT_MASTER);
      lock_q <= 1'b0;
      bl_q <= '0;
      cnt_q <= '0;
    end else begin
      grant_q <= grant_d;
      master_q <= master_d;
      rr_q <= rr_d;
      lock_q <= lock_d;
      bl_q <= bl_d;
      cnt_q <= cnt_d;
    end
  end
  assign HGRANT = grant_q;
  assign HMASTER = master_q;
  assign HMASTLOCK = lock_q;
endmodule

// File: tb/tb_ahb_arbiter_param.sv
// tb_ahb_arbiter_param: round-robin and fixed-priority arbiters driven in parallel, checked every
// cycle against a beat-counting model plus directed literal expectations.
module tb_ahb_arbiter_param;
  localparam int N = 4, MAXB = 16;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001, INCR4 = 3'b011;
  logic HCLK = 0, HRESETn = 0, HREADY = 1;
  logic [N-1:0] HREQ = '0, HLOCK = '0;
  logic [1:0] HTRANS = IDLE;
  logic [2:0] HBURST = SINGLE;
  logic [N-1:0] g0, g1;
  logic [1:0] m0, m1;
  logic l0, l1;
  int n_chk = 0, n_fail = 0;
  always #5 HCLK = ~HCLK;
  ahb_arbiter_param #(.NUM_MASTERS(N), .PRIORITY_MODE(0), .DEFAULT_MASTER(0), .MAX_INCR_BEATS(MAXB)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY), .HTRANS(HTRANS),
    .HBURST(HBURST), .HGRANT(g0), .HMASTER(m0), .HMASTLOCK(l0));
  ahb_arbiter_param #(.NUM_MASTERS(N), .PRIORITY_MODE(1), .DEFAULT_MASTER(0), .MAX_INCR_BEATS(MAXB)) dut_fx (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY), .HTRANS(HTRANS),
    .HBURST(HBURST), .HGRANT(g1), .HMASTER(m1), .HMASTLOCK(l1));
  // model state: owner, presented master/lock, last winner, burst length, beats done, INCR beats
  typedef struct {int o; int h; int l; int last; int len; int done; int incr;} mst_t;
  mst_t ms[2];
  function automatic int blen(logic [2:0] b);
    return b == INCR ? 0 : b == SINGLE ? 1 : 2 << b[2:1];
  endfunction
  function automatic mst_t nxt(mst_t s, int mode);
    mst_t n = s;
    int ci = 0, w = 0;
    bit fin = 0, cut, hand;
    logic [N-1:0] oth = HREQ;
    oth[s.o] = 1'b0;
    n.h = s.o;
    n.l = int'(HLOCK[s.o]);
    if (HTRANS == NS) begin
      n.len = blen(HBURST); n.done = 1; n.incr = 1; fin = n.len == 1; ci = 1;
    end else if (HTRANS == SEQ) begin
      n.done = s.done + 1; fin = s.len > 1 && n.done == s.len;
      n.incr = s.incr < MAXB ? s.incr + 1 : MAXB; ci = s.incr + 1;
    end
    cut = HBURST == INCR && ci >= MAXB && oth != 0;
    hand = !(HLOCK[s.o] && HREQ[s.o]) && (HTRANS == IDLE || fin || cut);
    if (hand) begin
      if (HREQ != 0) begin
        if (mode == 1) begin
          for (int k = N - 1; k >= 0; k--) if (HREQ[k]) w = k;
        end else begin
          for (int k = N; k >= 1; k--) if (HREQ[(s.last + k) % N]) w = (s.last + k) % N;
        end
      end
      n.o = w; n.last = w;
    end
    return n;
  endfunction
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ms[0] <= '{default: 0};
      ms[1] <= '{default: 0};
    end else if (HREADY) begin
      ms[0] <= nxt(ms[0], 0);
      ms[1] <= nxt(ms[1], 1);
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  always @(negedge HCLK) begin
    check("model_g_rr", 32'(g0), 32'(1) << ms[0].o);
    check("model_m_rr", 32'(m0), ms[0].h);
    check("model_l_rr", 32'(l0), ms[0].l);
    check("model_g_fx", 32'(g1), 32'(1) << ms[1].o);
    check("model_m_fx", 32'(m1), ms[1].h);
    check("model_l_fx", 32'(l1), ms[1].l);
  end
  task automatic drive(input logic [1:0] t, input logic [2:0] b, input logic rdy);
    HTRANS = t; HBURST = b; HREADY = rdy;
    @(negedge HCLK);
  endtask
  task automatic do_reset();
    HTRANS = IDLE; HREADY = 1; HLOCK = '0; HRESETn = 0;
    @(negedge HCLK);
    HRESETn = 1;
  endtask
  initial begin
    logic [N-1:0] rot [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (2) @(negedge HCLK);
    check("t1_grant", 32'(g0), 1);
    check("t1_hmaster", 32'(m0), 0);
    check("t1_mastlock", 32'(l0), 0);
    check("t1_grant_fx", 32'(g1), 1);
    HRESETn = 1; HREQ = 4'b0011;
    drive(NS, INCR4, 1);
    check("t2_beat1", 32'(g0), 1);
    repeat (2) drive(SEQ, INCR4, 1);
    check("t2_beat3", 32'(g0), 1);
    for (int i = 0; i < 5; i++) begin
      drive(SEQ, INCR4, 0);
      check("t6_freeze", 32'(g0), 1);
    end
    drive(SEQ, INCR4, 1);
    check("t2_handover", 32'(g0), 2);
    check("t2_hmaster_old", 32'(m0), 0);
    drive(NS, INCR4, 1);
    check("t2_grant_m1", 32'(g0), 2);
    check("t2_hmaster_new", 32'(m0), 1);
    drive(SEQ, INCR4, 1);
    #2 HRESETn = 0;
    #1 check("t6_async_grant", 32'(g0), 1);
    check("t6_async_hmaster", 32'(m0), 0);
    @(negedge HCLK);
    HRESETn = 1;
    repeat (2) drive(SEQ, INCR4, 1);
    check("t6_beats_cleared", 32'(g0), 1);
    do_reset();
    HREQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(IDLE, SINGLE, 1);
      check("t3_rotate", 32'(g0), 32'(rot[i]));
      check("t3_fixed", 32'(g1), 1);
    end
    do_reset();
    HREQ = 4'b1010;
    drive(IDLE, SINGLE, 1);
    check("t4_fixed_low", 32'(g1), 2);
    HREQ = 4'b1000;
    drive(IDLE, SINGLE, 1);
    check("t4_fixed_m3", 32'(g1), 8);
    check("t4_hmaster", 32'(m1), 1);
    do_reset();
    HREQ = 4'b0100;
    drive(IDLE, SINGLE, 1);
    check("t5_grant_m2", 32'(g0), 4);
    HREQ = 4'b0110; HLOCK = 4'b0100;
    drive(NS, INCR, 1);
    repeat (19) drive(SEQ, INCR, 1);
    check("t5_lock_hold", 32'(g0), 4);
    check("t5_mastlock", 32'(l0), 1);
    check("t5_hmaster", 32'(m0), 2);
    check("t5_lock_fx", 32'(g1), 4);
    HLOCK = '0;
    drive(NS, INCR, 1);
    repeat (14) drive(SEQ, INCR, 1);
    check("t5_beat15", 32'(g0), 4);
    drive(SEQ, INCR, 1);
    check("t5_cut", 32'(g0), 2);
    check("t5_cut_fx", 32'(g1), 2);
    HREQ = 4'b0100;
    drive(BUSY, INCR, 1);
    check("busy_hold", 32'(g0), 2);
    drive(IDLE, INCR, 1);
    check("idle_move", 32'(g0), 4);
    HREQ = '0;
    drive(IDLE, SINGLE, 1);
    check("default_master", 32'(g0), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
